// File: rtl/psram_xfer_sched_pkg.sv
// Shared definitions for the PSRAM transfer scheduler: FSM encodings,
// the global-reset command code, response ids and the latched transfer payload.
package psram_xfer_sched_pkg;

    typedef enum logic [2:0] {
        PSRAM_SCHED_INIT  = 3'd0,
        PSRAM_SCHED_IDLE  = 3'd1,
        PSRAM_SCHED_ISSUE = 3'd2,
        PSRAM_SCHED_WAIT  = 3'd3,
        PSRAM_SCHED_RESP  = 3'd4
    } sched_state_t;

    localparam logic [7:0] PSRAM_GLB_RST_CMD = 8'hFF;

    localparam logic PSRAM_RSP_ID_MEM = 1'b0;
    localparam logic PSRAM_RSP_ID_CMD = 1'b1;

    // Everything the core needs for one transfer, plus who asked for it.
    typedef struct packed {
        logic        rdwr;
        logic        cflg;
        logic [7:0]  ccmd;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        id;
    } xfer_req_t;

endpackage

// File: rtl/psram_rr_arb2.sv
// Two-way round-robin arbiter between the memory and command requesters.
// The pointer remembers the last winner; a tie goes to the other side.
module psram_rr_arb2
    import psram_xfer_sched_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_mem_i,
    input  logic req_cmd_i,
    input  logic update_i,
    output logic gnt_mem_o,
    output logic gnt_cmd_o
);

    logic last_id;

    // NOTE: both grants are assigned on every path, so no latch can be inferred.
    always_comb begin
        gnt_cmd_o = en_i && req_cmd_i && (!req_mem_i || (last_id == PSRAM_RSP_ID_MEM));
        gnt_mem_o = en_i && req_mem_i && (!req_cmd_i || (last_id == PSRAM_RSP_ID_CMD));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_id <= PSRAM_RSP_ID_MEM;
        end else if (update_i) begin
            last_id <= gnt_cmd_o ? PSRAM_RSP_ID_CMD : PSRAM_RSP_ID_MEM;
        end
    end

endmodule

// File: rtl/psram_xfer_sched.sv
// PSRAM transfer scheduler: arbitrates mem/cmd requesters, runs the one-shot
// global-reset command, sequences each core transfer with a timeout and returns a response.
module psram_xfer_sched
    import psram_xfer_sched_pkg::*;
#(
    parameter int TMO_WIDTH   = 16,
    parameter bit INIT_RST_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [TMO_WIDTH-1:0] cfg_tmo_i,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  logic                 mem_rdwr_i,
    input  logic [31:0]          mem_addr_i,
    input  logic [7:0]           mem_wdata_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_rdwr_i,
    input  logic [7:0]           cmd_code_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [7:0]           cmd_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_id_o,
    output logic                 rsp_err_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 xfer_en_o,
    output logic                 xfer_rdwr_o,
    output logic                 xfer_cflg_o,
    output logic [7:0]           xfer_ccmd_o,
    output logic [31:0]          xfer_addr_o,
    output logic [7:0]           xfer_data_o,
    input  logic                 xfer_done_i,
    input  logic [31:0]          xfer_rdata_i,
    output logic                 init_done_o,
    output logic                 busy_o,
    output logic                 tmo_flag_o,
    input  logic                 tmo_clr_i
);

    localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);

    sched_state_t         state;
    xfer_req_t            req_q;
    logic [TMO_WIDTH-1:0] timer;
    logic                 arb_en;
    logic                 gnt_mem;
    logic                 gnt_cmd;
    logic                 mem_fire;
    logic                 cmd_fire;
    logic                 tmo_hit;

    assign arb_en   = (state == PSRAM_SCHED_IDLE) && init_done_o;
    assign mem_fire = mem_valid_i && gnt_mem;
    assign cmd_fire = cmd_valid_i && gnt_cmd;

    psram_rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (arb_en),
        .req_mem_i (mem_valid_i),
        .req_cmd_i (cmd_valid_i),
        .update_i  (mem_fire || cmd_fire),
        .gnt_mem_o (gnt_mem),
        .gnt_cmd_o (gnt_cmd)
    );

    assign mem_ready_o = gnt_mem;
    assign cmd_ready_o = gnt_cmd;

    // A timer loaded with 0 saturates there and never reaches 1, disabling expiry.
    assign tmo_hit = (state == PSRAM_SCHED_WAIT) && !xfer_done_i && (timer == TMO_ONE);

    assign busy_o      = (state != PSRAM_SCHED_IDLE);
    assign xfer_rdwr_o = req_q.rdwr;
    assign xfer_cflg_o = req_q.cflg;
    assign xfer_ccmd_o = req_q.ccmd;
    assign xfer_addr_o = req_q.addr;
    assign xfer_data_o = req_q.data;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= INIT_RST_EN ? PSRAM_SCHED_INIT : PSRAM_SCHED_IDLE;
            req_q       <= '0;
            timer       <= '0;
            xfer_en_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            init_done_o <= !INIT_RST_EN;
        end else begin
            xfer_en_o <= 1'b0;
            case (state)
                PSRAM_SCHED_INIT: begin
                    req_q <= '{rdwr: 1'b0, cflg: 1'b1, ccmd: PSRAM_GLB_RST_CMD,
                               addr: 32'h0, data: 8'h0, id: PSRAM_RSP_ID_CMD};
                    xfer_en_o <= 1'b1;
                    state     <= PSRAM_SCHED_ISSUE;
                end
                PSRAM_SCHED_IDLE: begin
                    if (mem_fire) begin
                        req_q <= '{rdwr: mem_rdwr_i, cflg: 1'b0, ccmd: 8'h0,
                                   addr: mem_addr_i, data: mem_wdata_i, id: PSRAM_RSP_ID_MEM};
                        xfer_en_o <= 1'b1;
                        state     <= PSRAM_SCHED_ISSUE;
                    end else if (cmd_fire) begin
                        req_q <= '{rdwr: cmd_rdwr_i, cflg: 1'b1, ccmd: cmd_code_i,
                                   addr: cmd_addr_i, data: cmd_data_i, id: PSRAM_RSP_ID_CMD};
                        xfer_en_o <= 1'b1;
                        state     <= PSRAM_SCHED_ISSUE;
                    end
                end
                PSRAM_SCHED_ISSUE: begin
                    timer <= cfg_tmo_i;
                    state <= PSRAM_SCHED_WAIT;
                end
                PSRAM_SCHED_WAIT: begin
                    if (xfer_done_i || tmo_hit) begin
                        // The power-up command completes silently; everything else responds.
                        if (init_done_o) begin
                            rsp_valid_o <= 1'b1;
                            rsp_id_o    <= req_q.id;
                            rsp_err_o   <= !xfer_done_i;
                            rsp_rdata_o <= (xfer_done_i && req_q.rdwr) ? xfer_rdata_i : 32'h0;
                            state       <= PSRAM_SCHED_RESP;
                        end else begin
                            init_done_o <= 1'b1;
                            state       <= PSRAM_SCHED_IDLE;
                        end
                    end else if (timer != '0) begin
                        timer <= timer - TMO_ONE;
                    end
                end
                PSRAM_SCHED_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= PSRAM_SCHED_IDLE;
                    end
                end
                default: state <= PSRAM_SCHED_IDLE;
            endcase
        end
    end

    // Set has priority so a clear landing on the expiry cycle cannot lose the event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_flag_o <= 1'b0;
        end else if (tmo_hit) begin
            tmo_flag_o <= 1'b1;
        end else if (tmo_clr_i) begin
            tmo_flag_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psram_xfer_sched.sv
// Self-checking bench for psram_xfer_sched: a delayed-done core model, a
// response scoreboard and directed scenarios for init, arbitration, timeout and reset.
module tb_psram_xfer_sched;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } rsp_exp_t;

    logic        clk;
    logic        rst_i;
    logic [15:0] cfg_tmo_i;
    logic        mem_valid_i, mem_ready_o, mem_rdwr_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_wdata_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_rdwr_i;
    logic [7:0]  cmd_code_i, cmd_data_i;
    logic [31:0] cmd_addr_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        xfer_en_o, xfer_rdwr_o, xfer_cflg_o;
    logic [7:0]  xfer_ccmd_o, xfer_data_o;
    logic [31:0] xfer_addr_o;
    logic        xfer_done_i;
    logic [31:0] xfer_rdata_i;
    logic        init_done_o, busy_o, tmo_flag_o, tmo_clr_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    rsp_exp_t sb[$];
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    int hs_cyc = 0;

    int          core_delay = 20;
    int          en_cnt = 0;
    int          en_cyc = 0;
    int          done_cyc = 0;
    logic [7:0]  en_ccmd = 8'h0;
    logic [7:0]  en_data = 8'h0;
    logic        en_cflg = 1'b0;
    logic [31:0] en_addr = 32'h0;

    psram_xfer_sched #(.TMO_WIDTH(16), .INIT_RST_EN(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_tmo_i    (cfg_tmo_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_rdwr_i   (mem_rdwr_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_rdwr_i   (cmd_rdwr_i),
        .cmd_code_i   (cmd_code_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_data_i   (cmd_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .xfer_en_o    (xfer_en_o),
        .xfer_rdwr_o  (xfer_rdwr_o),
        .xfer_cflg_o  (xfer_cflg_o),
        .xfer_ccmd_o  (xfer_ccmd_o),
        .xfer_addr_o  (xfer_addr_o),
        .xfer_data_o  (xfer_data_o),
        .xfer_done_i  (xfer_done_i),
        .xfer_rdata_i (xfer_rdata_i),
        .init_done_o  (init_done_o),
        .busy_o       (busy_o),
        .tmo_flag_o   (tmo_flag_o),
        .tmo_clr_i    (tmo_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read data returned by the core model; 0x100 maps to 0xDEADBEEF.
    function automatic logic [31:0] core_rdata(input logic [31:0] a);
        return a + 32'hDEAD_BDEF;
    endfunction

    // Core model: on xfer_en, pulse done core_delay cycles later (0 = never).
    initial begin
        bit aborted;
        xfer_done_i  = 1'b0;
        xfer_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (xfer_en_o && !rst_i) begin
                en_cnt++;
                en_cyc  = cyc;
                en_ccmd = xfer_ccmd_o;
                en_cflg = xfer_cflg_o;
                en_addr = xfer_addr_o;
                en_data = xfer_data_o;
                if (core_delay > 0) begin
                    aborted = 1'b0;
                    for (int k = 0; k < core_delay; k++) begin
                        @(negedge clk);
                        if (rst_i) begin
                            aborted = 1'b1;
                            break;
                        end
                        check("addr_hold", xfer_addr_o, en_addr);
                    end
                    if (!aborted) begin
                        xfer_done_i  = 1'b1;
                        xfer_rdata_i = core_rdata(xfer_addr_o);
                        done_cyc     = cyc;
                        @(negedge clk);
                        xfer_done_i  = 1'b0;
                        xfer_rdata_i = 32'h0;
                    end
                end
            end
        end
    end

    // Response monitor: counts rising edges and pops the scoreboard on acceptance.
    initial begin
        rsp_exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid_o && !prev_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
            end
            prev_valid = rsp_valid_o;
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id_o), 32'(e.id));
                    check("rsp_err", 32'(rsp_err_o), 32'(e.err));
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                end
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_ctrl"}, {22'd0, xfer_en_o, xfer_rdwr_o, xfer_cflg_o, rsp_valid_o, rsp_id_o,
                               rsp_err_o, tmo_flag_o, mem_ready_o, cmd_ready_o, init_done_o}, 32'd0);
        check({tag, "_xaddr"}, xfer_addr_o, 32'd0);
        check({tag, "_ccmd_data"}, {16'd0, xfer_ccmd_o, xfer_data_o}, 32'd0);
        check({tag, "_rdata"}, rsp_rdata_o, 32'd0);
    endtask

    task automatic do_mem(input logic rd, input logic [31:0] addr, input logic [7:0] wd,
                          input logic exp_err);
        rsp_exp_t e;
        bit got;
        got = 1'b0;
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_rdwr_i  = rd;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (mem_ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mem_grant", 32'(got), 32'd1);
        hs_cyc  = cyc;
        e.id    = 1'b0;
        e.err   = exp_err;
        e.rdata = (rd && !exp_err) ? core_rdata(addr) : 32'h0;
        sb.push_back(e);
        @(posedge clk);
        #1 mem_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int bound);
        int start;
        bit seen;
        start = rsp_cnt;
        seen  = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (rsp_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
        check("rsp_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_init_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (init_done_o) break;
        end
        check("init_done", 32'(init_done_o), 32'd1);
    endtask

    task automatic wait_sb_empty(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic exp_cmd [3];
        rsp_exp_t e;
        int base_en;
        int base_rsp;
        bit got;

        rst_i = 1'b1; cfg_tmo_i = 16'd0; tmo_clr_i = 1'b0; rsp_ready_i = 1'b1;
        mem_valid_i = 1'b0; mem_rdwr_i = 1'b0; mem_addr_i = 32'h0; mem_wdata_i = 8'h0;
        cmd_valid_i = 1'b0; cmd_rdwr_i = 1'b0; cmd_code_i = 8'h0; cmd_addr_i = 32'h0;
        cmd_data_i = 8'h0;
        core_delay = 20;
        repeat (3) @(negedge clk);
        #1 reset_checks("por");
        #1 rst_i = 1'b0;

        // Power-up global-reset command.
        wait_init_done(100);
        check("init_done_lat", 32'(cyc), 32'(done_cyc + 1));
        check("init_en_cnt", 32'(en_cnt), 32'd1);
        check("init_ccmd", 32'(en_ccmd), 32'h0000_00FF);
        check("init_cflg", 32'(en_cflg), 32'd1);
        check("init_no_rsp", 32'(rsp_cnt), 32'd0);
        check("idle_ready_quiet", {30'd0, mem_ready_o, cmd_ready_o}, 32'd0);

        // mem read with response back-pressure.
        rsp_ready_i = 1'b0;
        core_delay  = 6;
        do_mem(1'b1, 32'h0000_0100, 8'h00, 1'b0);
        wait_rsp(100);
        check("issue_lat", 32'(en_cyc), 32'(hs_cyc + 1));
        check("rsp_lat", 32'(rsp_cyc), 32'(done_cyc + 1));
        for (int i = 0; i < 3; i++) begin
            check("rsp_hold_valid", 32'(rsp_valid_o), 32'd1);
            check("rsp_hold_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
            check("rsp_hold_id", 32'(rsp_id_o), 32'd0);
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 check("idle_after_rsp", 32'(busy_o), 32'd0);
        wait_sb_empty(20);

        // Both requesters valid for three transfers: pointer starts at "mem last".
        core_delay = 3;
        exp_cmd[0] = 1'b1; exp_cmd[1] = 1'b0; exp_cmd[2] = 1'b1;
        @(negedge clk);
        mem_valid_i = 1'b1; mem_rdwr_i = 1'b1; mem_addr_i = 32'h0000_0300; mem_wdata_i = 8'h00;
        cmd_valid_i = 1'b1; cmd_rdwr_i = 1'b0; cmd_code_i = 8'h35;
        cmd_addr_i = 32'h0000_0200; cmd_data_i = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            got = 1'b0;
            for (int k = 0; k < 100; k++) begin
                #1;
                if (mem_ready_o || cmd_ready_o) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("grant_seen", 32'(got), 32'd1);
            check("grant_order", {30'd0, cmd_ready_o, mem_ready_o}, exp_cmd[i] ? 32'd2 : 32'd1);
            e.id    = exp_cmd[i];
            e.err   = 1'b0;
            e.rdata = exp_cmd[i] ? 32'h0 : core_rdata(32'h0000_0300);
            sb.push_back(e);
            base_en = en_cnt;
            @(posedge clk);
            if (i == 2) begin
                #1;
                mem_valid_i = 1'b0;
                cmd_valid_i = 1'b0;
            end
            @(negedge clk);
            #1;
            check("grant_en", 32'(en_cnt), 32'(base_en + 1));
            check("grant_cflg", 32'(en_cflg), 32'(exp_cmd[i]));
            check("grant_ccmd", 32'(en_ccmd), exp_cmd[i] ? 32'h35 : 32'h0);
            check("grant_addr", en_addr, exp_cmd[i] ? 32'h0000_0200 : 32'h0000_0300);
        end
        wait_sb_empty(200);

        // Timeout with the clear held through expiry: set wins, then clear takes effect.
        cfg_tmo_i  = 16'd5;
        core_delay = 0;
        tmo_clr_i  = 1'b1;
        do_mem(1'b0, 32'h0000_0500, 8'h77, 1'b1);
        wait_rsp(100);
        check("tmo_lat", 32'(rsp_cyc), 32'(en_cyc + 6));
        check("tmo_flag_set", 32'(tmo_flag_o), 32'd1);
        check("tmo_err_out", 32'(rsp_err_o), 32'd1);
        @(posedge clk);
        #1 tmo_clr_i = 1'b0;
        @(negedge clk);
        #1 check("tmo_flag_clr", 32'(tmo_flag_o), 32'd0);
        wait_sb_empty(20);

        // Done lands on the same cycle the timer reaches 1.
        cfg_tmo_i  = 16'd4;
        core_delay = 4;
        do_mem(1'b1, 32'h0000_0400, 8'h00, 1'b0);
        wait_rsp(100);
        check("coinc_lat", 32'(rsp_cyc), 32'(done_cyc + 1));
        check("coinc_flag", 32'(tmo_flag_o), 32'd0);
        wait_sb_empty(20);

        // Reset in the middle of WAIT aborts the transfer and reruns INIT.
        cfg_tmo_i  = 16'd0;
        core_delay = 10;
        do_mem(1'b1, 32'h0000_0600, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_i = 1'b1;
        sb.delete();
        #1 reset_checks("mid_rst");
        check("mid_rst_busy", 32'(busy_o), 32'd1);
        base_en   = en_cnt;
        base_rsp  = rsp_cnt;
        core_delay = 5;
        @(negedge clk);
        #2 rst_i = 1'b0;
        wait_init_done(100);
        check("reinit_en_cnt", 32'(en_cnt), 32'(base_en + 1));
        check("reinit_ccmd", 32'(en_ccmd), 32'h0000_00FF);
        check("reinit_cflg", 32'(en_cflg), 32'd1);
        check("abort_no_rsp", 32'(rsp_cnt), 32'(base_rsp));

        // Normal operation resumes after re-init.
        core_delay = 3;
        do_mem(1'b0, 32'h0000_0700, 8'hC3, 1'b0);
        wait_sb_empty(100);
        check("final_wdata", 32'(en_data), 32'h0000_00C3);
        check("final_cflg", 32'(en_cflg), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
